// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage.
//   FETCH_XLEN      default datapath width (PC, addresses)
//   FETCH_XLEN_MAX  widest supported datapath; sizes the IF/ID payload fields
//   NOP_INSTR       canonical NOP (addi x0,x0,0) injected on flush/reset
//   ifid_t          IF/ID pipeline payload: valid, pc, pc_plus4, instr
//   misaligned()    true when a target is not word aligned
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_XLEN     = 32;
  localparam int FETCH_XLEN_MAX = 64;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // PC fields are sized for the widest legal XLEN; narrower builds keep the
  // upper bits at zero and they are optimised away.
  typedef struct packed {
    logic                      valid;
    logic [FETCH_XLEN_MAX-1:0] pc;
    logic [FETCH_XLEN_MAX-1:0] pc_plus4;
    logic [31:0]               instr;
  } ifid_t;

  function automatic logic misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// ----------------------------------------------------------------------------
// fetch_if
// Bundles the fetch stage's control inputs, instruction-memory port and
// IF/ID outputs.
//   master modport : the fetch stage (drives imem_addr and the id_* outputs)
//   slave  modport : the environment (pipeline control + instruction memory)
// Signals:
//   stall, redirect_valid, redirect_target  pipeline control into fetch
//   imem_addr / imem_rdata                  async-read instruction memory
//   id_valid, id_pc, id_pc_plus4, id_instr  IF/ID register contents
//   misalign_err                            one-cycle misaligned-redirect flag
// ----------------------------------------------------------------------------
interface fetch_if #(
  parameter int XLEN = 32
);

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic [31:0]     id_instr;
  logic            misalign_err;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_rdata,
    output imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, misalign_err
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, misalign_err
  );

endinterface

// File: rtl/fetch_perf_counters.sv
// ----------------------------------------------------------------------------
// fetch_perf_counters
// Three saturating 32-bit event counters for the fetch stage.
// Ports:
//   CLK, reset    clock and synchronous active-low reset (clears counters)
//   inc_fetched   one instruction advanced into IF/ID this cycle
//   inc_stall     cycle stalled without a redirect
//   inc_flush     redirect accepted this cycle
//   perf_fetched, perf_stalls, perf_flushes   counter values
// ----------------------------------------------------------------------------
module fetch_perf_counters (
  input  logic        CLK,
  input  logic        reset,
  input  logic        inc_fetched,
  input  logic        inc_stall,
  input  logic        inc_flush,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
);

  logic [2:0]  inc_vec;
  logic [31:0] cnt_vec [3];

  assign inc_vec = {inc_flush, inc_stall, inc_fetched};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [31:0] cnt_reg;

      // Counters stick at all-ones rather than wrapping.
      always_ff @(posedge CLK) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (inc_vec[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end

      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  assign perf_fetched = cnt_vec[0];
  assign perf_stalls  = cnt_vec[1];
  assign perf_flushes = cnt_vec[2];

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, presents it to an async-read
// instruction memory and captures the returned word into the IF/ID register.
// Priority each edge: reset (active low) > redirect > stall > advance.
// Ports:
//   CLK           single clock, rising edge
//   reset         synchronous active-low reset
//   bus           fetch_if.master (control in, imem port, IF/ID outputs)
//   perf_fetched, perf_stalls, perf_flushes   performance counters
// Parameters:
//   XLEN          32 or 64
//   RESET_VECTOR  PC after reset, word aligned
// Build option:
//   FETCH_PERF_EN  when defined, counters are implemented in
//                  fetch_perf_counters; otherwise perf ports read 0.
// ----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN         = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic        CLK,
  input  logic        reset,
  fetch_if.master     bus,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  ifid_t           ifid_reg;
  ifid_t           ifid_next;
  logic            misalign_reg;
  logic            misalign_next;

  // Natural modulo-2^XLEN wrap from all-ones-minus-3 back to zero.
  assign pc_plus4 = pc_reg + XLEN'(4);

  always_comb begin
    pc_next       = pc_reg;
    ifid_next     = ifid_reg;
    misalign_next = 1'b0;
    if (bus.redirect_valid) begin
      // Flush: bubble into IF/ID, keep the old pc/pc_plus4 fields.
      pc_next         = {bus.redirect_target[XLEN-1:2], 2'b00};
      ifid_next.valid = 1'b0;
      ifid_next.instr = NOP_INSTR;
      misalign_next   = misaligned(bus.redirect_target[1:0]);
    end else if (!bus.stall) begin
      pc_next            = pc_plus4;
      ifid_next.valid    = 1'b1;
      ifid_next.pc       = FETCH_XLEN_MAX'(pc_reg);
      ifid_next.pc_plus4 = FETCH_XLEN_MAX'(pc_plus4);
      ifid_next.instr    = bus.imem_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      pc_reg             <= RESET_VECTOR;
      ifid_reg.valid     <= 1'b0;
      ifid_reg.pc        <= '0;
      ifid_reg.pc_plus4  <= '0;
      ifid_reg.instr     <= NOP_INSTR;
      misalign_reg       <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      ifid_reg     <= ifid_next;
      misalign_reg <= misalign_next;
    end
  end

  assign bus.imem_addr    = pc_reg;
  assign bus.id_valid     = ifid_reg.valid;
  assign bus.id_pc        = XLEN'(ifid_reg.pc);
  assign bus.id_pc_plus4  = XLEN'(ifid_reg.pc_plus4);
  assign bus.id_instr     = ifid_reg.instr;
  assign bus.misalign_err = misalign_reg;

`ifdef FETCH_PERF_EN
  logic inc_fetched;
  logic inc_stall;
  logic inc_flush;

  assign inc_fetched = !bus.redirect_valid && !bus.stall;
  assign inc_stall   = !bus.redirect_valid &&  bus.stall;
  assign inc_flush   =  bus.redirect_valid;

  fetch_perf_counters u_perf (
    .CLK          (CLK),
    .reset        (reset),
    .inc_fetched  (inc_fetched),
    .inc_stall    (inc_stall),
    .inc_flush    (inc_flush),
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes)
  );
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

endmodule
